mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module   : mem_arbiter_if
// Purpose  : Requester ports plus the shared memory port of the arbiter.
// Revision : 1.0
// =============================================================================
interface mem_arbiter_if;
    logic        p0_req;
    logic        p1_req;
    logic        p0_we;
    logic        p1_we;
    logic [31:0] p0_addr;
    logic [31:0] p1_addr;
    logic [31:0] p0_wdata;
    logic [31:0] p1_wdata;
    logic [3:0]  p0_wmask;
    logic [3:0]  p1_wmask;
    logic        p0_ack;
    logic        p1_ack;
    logic [31:0] p0_rdata;
    logic [31:0] p1_rdata;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        busy;

    // Arbiter side
    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, p0_wmask, p1_wmask, mem_rdata,
        output p0_ack, p1_ack, p0_rdata, p1_rdata,
               mem_addr, mem_rstrb, mem_wdata, mem_wmask, busy
    );

    // Requesters and memory side
    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, p0_wmask, p1_wmask, mem_rdata,
        input  p0_ack, p1_ack, p0_rdata, p1_rdata,
               mem_addr, mem_rstrb, mem_wdata, mem_wmask, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (fetch / load-store) arbiter onto one memory port,
//            three cycles per access, round-robin or fixed tie-break.
// Revision : 1.0
// =============================================================================
module mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        grant;
    logic        last_grant;
    logic        grant_we;
    logic        grant_next;
    logic        start;
    logic        p0_elig;
    logic        p1_elig;
    logic        p0_ack;
    logic        p1_ack;
    logic [31:0] p0_rdata;
    logic [31:0] p1_rdata;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wmask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;

    // A port whose ack is showing this cycle is not regranted immediately.
    always_comb begin
        p0_elig = bus.p0_req & ~p0_ack;
        p1_elig = bus.p1_req & ~p1_ack;
        if (p0_elig && p1_elig) begin
            grant_next = FIXED_PRIO ? 1'b1 : ~last_grant;
        end else begin
            grant_next = p1_elig;
        end
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (p0_elig || p1_elig) begin
                    state_next = ACCESS;
                    start      = 1'b1;
                end
            end
            ACCESS:  state_next = WAIT;
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address/data are taken live from the granted port; strobes die under reset.
    always_comb begin
        sel_addr  = grant ? bus.p1_addr  : bus.p0_addr;
        sel_wdata = grant ? bus.p1_wdata : bus.p0_wdata;
        sel_wmask = grant ? bus.p1_wmask : bus.p0_wmask;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wmask = 4'd0;
        mem_rstrb = 1'b0;
        if (state == ACCESS) begin
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
            if (!reset) begin
                mem_rstrb = ~grant_we;
                mem_wmask = grant_we ? sel_wmask : 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= 32'd0;
            p1_rdata   <= 32'd0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            grant_we   <= 1'b0;
        end else begin
            state  <= state_next;
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            if (start) begin
                grant      <= grant_next;
                last_grant <= grant_next;
                grant_we   <= grant_next ? bus.p1_we : bus.p0_we;
            end
            if (state == WAIT) begin
                if (grant) begin
                    p1_ack <= 1'b1;
                    if (!grant_we) p1_rdata <= bus.mem_rdata;
                end else begin
                    p0_ack <= 1'b1;
                    if (!grant_we) p0_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.p0_ack    = p0_ack;
    assign bus.p1_ack    = p1_ack;
    assign bus.p0_rdata  = p0_rdata;
    assign bus.p1_rdata  = p1_rdata;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_wmask = mem_wmask;
    assign bus.mem_rstrb = mem_rstrb;
    assign bus.busy      = (state != IDLE);
endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Randomised scoreboard bench; one lane per tie-break mode.
// Revision : 1.0
// =============================================================================
module tb_mem_arbiter;
    localparam int RUN_CYCLES = 800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        int          acc_cyc;
        int          ack_cyc;
    } txn_t;

    task automatic chk(input int lane, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL lane%0d %s: got %h, expected %h", lane, nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 36) return 32'h0403_0201;   // word behind byte address 0x190
        return 32'hA500_0000 | (32'(i) * 32'h0001_0203);
    endfunction

    for (genvar G = 0; G < 2; G++) begin : g_lane
        mem_arbiter_if bus();
        logic reset;
        bit   stop;
        bit   done_flag = 1'b0;

        mem_arbiter #(.FIXED_PRIO(G == 1)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        txn_t        q[$];
        int          cyc = 0;
        bit          armed = 1'b0;
        logic        last_g = 1'b1;
        int          ack_cyc_seen = -1;
        logic        ack_port_seen = 1'b0;
        logic [31:0] exp_rdata [2];
        logic [31:0] mmem [64];
        logic [31:0] tmem [64];

        assign bus.p0_req   = g_port[0].req;
        assign bus.p1_req   = g_port[1].req;
        assign bus.p0_we    = g_port[0].we;
        assign bus.p1_we    = g_port[1].we;
        assign bus.p0_addr  = g_port[0].addr;
        assign bus.p1_addr  = g_port[1].addr;
        assign bus.p0_wdata = g_port[0].wdata;
        assign bus.p1_wdata = g_port[1].wdata;
        assign bus.p0_wmask = g_port[0].wmask;
        assign bus.p1_wmask = g_port[1].wmask;

        // Memory the DUT talks to: data appears the cycle after the strobe, noise otherwise.
        always @(posedge clk) begin : mem_emul
            logic [31:0] w;
            int          idx;
            idx = int'(bus.mem_addr[7:2]);
            w   = tmem[idx];
            for (int b = 0; b < 4; b++)
                if (bus.mem_wmask[b] === 1'b1) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            tmem[idx] = w;
            bus.mem_rdata <= (bus.mem_rstrb === 1'b1) ? tmem[idx] : $urandom;
        end

        // Reference model: a granted transaction occupies the memory for the
        // following cycle and is acknowledged two cycles after that.
        always @(posedge clk) begin : model
            logic e0, e1, g;
            txn_t t;
            int   idx;
            if (reset) begin
                q.delete();
                last_g       = 1'b1;
                exp_rdata[0] = 32'd0;
                exp_rdata[1] = 32'd0;
                armed        = 1'b1;
            end else if (armed) begin
                if (q.size() > 0 && q[0].acc_cyc == cyc) begin
                    t   = q[0];
                    idx = int'(t.addr[7:2]);
                    if (t.we) begin
                        for (int b = 0; b < 4; b++)
                            if (t.wmask[b]) mmem[idx][8*b +: 8] = t.wdata[8*b +: 8];
                    end else begin
                        t.rdata = mmem[idx];
                    end
                    q[0] = t;
                end
                if (q.size() == 0) begin
                    e0 = g_port[0].req && !(ack_cyc_seen == cyc && ack_port_seen == 1'b0);
                    e1 = g_port[1].req && !(ack_cyc_seen == cyc && ack_port_seen == 1'b1);
                    if (e0 || e1) begin
                        if (e0 && e1) g = (G == 1) ? 1'b1 : ~last_g;
                        else          g = e1;
                        t.port    = g;
                        t.we      = g ? g_port[1].we    : g_port[0].we;
                        t.addr    = g ? g_port[1].addr  : g_port[0].addr;
                        t.wdata   = g ? g_port[1].wdata : g_port[0].wdata;
                        t.wmask   = g ? g_port[1].wmask : g_port[0].wmask;
                        t.rdata   = 32'd0;
                        t.acc_cyc = cyc + 1;
                        t.ack_cyc = cyc + 3;
                        q.push_back(t);
                        last_g = g;
                    end
                end
            end
            cyc++;
        end

        always @(negedge clk) begin : monitor
            txn_t        t;
            logic [1:0]  e_ack;
            logic        e_busy, e_rstrb;
            logic [3:0]  e_wmask;
            logic [31:0] e_addr, e_wdata;
            if (armed) begin
                e_ack = 2'b00; e_busy = 1'b0; e_rstrb = 1'b0;
                e_wmask = 4'd0; e_addr = 32'd0; e_wdata = 32'd0;
                if (q.size() > 0) begin
                    t = q[0];
                    if (cyc == t.acc_cyc) begin
                        e_busy  = 1'b1;
                        e_addr  = t.addr;
                        e_wdata = t.wdata;
                        if (!reset) begin
                            e_rstrb = ~t.we;
                            e_wmask = t.we ? t.wmask : 4'd0;
                        end
                    end
                    if (cyc == t.acc_cyc + 1) e_busy = 1'b1;
                    if (cyc == t.ack_cyc) begin
                        e_ack[t.port] = 1'b1;
                        if (!t.we) exp_rdata[t.port] = t.rdata;
                        ack_cyc_seen  = cyc;
                        ack_port_seen = t.port;
                        void'(q.pop_front());
                    end
                end
                chk(G, "busy",      32'(bus.busy),      32'(e_busy));
                chk(G, "p0_ack",    32'(bus.p0_ack),    32'(e_ack[0]));
                chk(G, "p1_ack",    32'(bus.p1_ack),    32'(e_ack[1]));
                chk(G, "p0_rdata",  bus.p0_rdata,       exp_rdata[0]);
                chk(G, "p1_rdata",  bus.p1_rdata,       exp_rdata[1]);
                chk(G, "mem_rstrb", 32'(bus.mem_rstrb), 32'(e_rstrb));
                chk(G, "mem_wmask", 32'(bus.mem_wmask), 32'(e_wmask));
                if (!reset) begin
                    chk(G, "mem_addr",  bus.mem_addr,  e_addr);
                    chk(G, "mem_wdata", bus.mem_wdata, e_wdata);
                end
            end
        end

        for (genvar P = 0; P < 2; P++) begin : g_port
            logic        req, we;
            logic [31:0] addr, wdata;
            logic [3:0]  wmask;
            wire         ack = (P == 0) ? bus.p0_ack : bus.p1_ack;

            initial begin : requester
                int waited, drop_after, gap;
                bit done, rs;
                req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; wmask = 4'd0;
                repeat (3) @(posedge clk);
                #1;
                // Opening tie: fetch read of 0x190 against a masked store to 0x10.
                if (P == 0) begin
                    we = 1'b0; addr = 32'h190; wdata = $urandom; wmask = 4'hF;
                end else begin
                    we = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF; wmask = 4'b0011;
                end
                while (!stop) begin
                    req        = 1'b1;
                    drop_after = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
                    waited     = 0;
                    done       = 1'b0;
                    while (!done) begin
                        @(posedge clk);
                        rs = reset;
                        #1;
                        waited++;
                        if (rs) done = 1'b1;
                        else if (ack) done = 1'b1;
                        else if (drop_after != 0 && waited == drop_after) req = 1'b0;
                        else if (drop_after != 0 && waited > drop_after + 4) done = 1'b1;
                        else if (waited > 40) begin
                            checks++;
                            failures++;
                            $display("FAIL lane%0d ack_wait port%0d: no ack after %0d cycles, required within 40", G, P, waited);
                            done = 1'b1;
                        end
                    end
                    gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
                    if (gap != 0) begin
                        req = 1'b0;
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    we    = 1'($urandom_range(0, 1));
                    addr  = $urandom & 32'hFFFF_FFFC;
                    wdata = $urandom;
                    wmask = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                end
                req = 1'b0;
            end
        end

        initial begin : control
            bit hit;
            int n;
            stop  = 1'b0;
            reset = 1'b1;
            for (int i = 0; i < 64; i++) begin
                mmem[i] = init_word(i);
                tmem[i] = init_word(i);
            end
            repeat (3) @(posedge clk);
            #1 reset = 1'b0;
            // Untargeted reset wherever the traffic happens to be.
            repeat (150 + 37 * G) @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            // Targeted reset landing on the memory cycle of a port-1 write.
            hit = 1'b0;
            n   = 0;
            while (!hit && n < 400) begin
                @(posedge clk);
                #1;
                n++;
                if (q.size() > 0 && q[0].we && q[0].port && q[0].acc_cyc == cyc) hit = 1'b1;
            end
            if (hit) begin
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end
            chk(G, "p1_write_access_for_reset", 32'(hit), 32'd1);
            while (cyc < RUN_CYCLES) @(posedge clk);
            stop = 1'b1;
            repeat (30) @(posedge clk);
            #1;
            chk(G, "queue_drained", 32'(q.size()), 32'd0);
            done_flag = 1'b1;
        end
    end

    initial begin : main
        int i;
        for (i = 0; i < 20000 && !(g_lane[0].done_flag && g_lane[1].done_flag); i++)
            @(posedge clk);
        if (!(g_lane[0].done_flag && g_lane[1].done_flag)) begin
            checks++;
            failures++;
            $display("FAIL lanes_done: still running after %0d cycles, required to finish", i);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
